// File: rtl/switch_event_scheduler.sv
// Classifies per-switch presses as SHORT / LONG / DOUBLE, queues one pending event per
// switch, and forwards them round-robin over a valid/ready port that also drives the LEDs.
module switch_event_scheduler #(
  parameter int NUM_SW      = 4,
  parameter int CLKS_PER_MS = 25000,
  parameter int LONG_MS     = 1000,
  parameter int DBL_MS      = 300
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_n,
  input  logic [NUM_SW-1:0]         i_Switch,
  output logic                      o_Evt_Valid,
  input  logic                      i_Evt_Ready,
  output logic [$clog2(NUM_SW)-1:0] o_Evt_Sw,
  output logic [1:0]                o_Evt_Type,
  output logic [NUM_SW-1:0]         o_LED,
  output logic                      o_Overflow
);

  localparam int SW_W = $clog2(NUM_SW);
  localparam int CW   = $clog2(LONG_MS + 1);
  localparam int PW   = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

  localparam logic [CW-1:0] CNT_LONG   = CW'(LONG_MS);
  localparam logic [CW-1:0] CNT_DBL    = CW'(DBL_MS);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_MS - 1);

  localparam logic [1:0] EVT_NONE   = 2'b00;
  localparam logic [1:0] EVT_SHORT  = 2'b01;
  localparam logic [1:0] EVT_LONG   = 2'b10;
  localparam logic [1:0] EVT_DOUBLE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS1,
    ST_HELD,
    ST_GAP,
    ST_PRESS2
  } sw_state_e;

  logic [PW-1:0]          presc_q, presc_d;
  logic                   tick;
  logic [NUM_SW-1:0]      prev_q;
  logic [NUM_SW-1:0]      emit;
  logic [NUM_SW-1:0][1:0] emit_type;

  logic [NUM_SW-1:0]      pend_q, pend_d;
  logic [NUM_SW-1:0][1:0] ptype_q, ptype_d;
  logic                   ovf_q, ovf_d;
  logic                   evt_valid_q, evt_valid_d;
  logic [SW_W-1:0]        evt_sw_q, evt_sw_d;
  logic [1:0]             evt_type_q, evt_type_d;
  logic [SW_W-1:0]        last_grant_q, last_grant_d;
  logic [NUM_SW-1:0]      led_q, led_d;

  logic                   hi_found, lo_found;
  logic [SW_W-1:0]        hi_idx, lo_idx, grant_idx;
  logic                   accept, out_free, load;

  assign tick    = (presc_q == PRESC_LAST);
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      presc_q <= '0;
      prev_q  <= '0;
    end else begin
      presc_q <= presc_d;
      prev_q  <= i_Switch;
    end
  end

  for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
    sw_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_edge, rel_edge, emit_l;
    logic [1:0]    type_l;

    assign press_edge = i_Switch[gi] & ~prev_q[gi];
    assign rel_edge   = ~i_Switch[gi] & prev_q[gi];

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      emit_l  = 1'b0;
      type_l  = EVT_NONE;
      case (state_q)
        ST_IDLE:   if (press_edge) state_d = ST_PRESS1;
        ST_PRESS1: begin
          // Release takes priority over the LONG threshold landing in the same cycle.
          if (rel_edge) begin
            state_d = ST_GAP;
          end else if (cnt_q == CNT_LONG) begin
            state_d = ST_HELD;
            emit_l  = 1'b1;
            type_l  = EVT_LONG;
          end
        end
        ST_HELD:   if (rel_edge) state_d = ST_IDLE;
        ST_GAP: begin
          if (press_edge) begin
            state_d = ST_PRESS2;
          end else if (cnt_q == CNT_DBL) begin
            state_d = ST_IDLE;
            emit_l  = 1'b1;
            type_l  = EVT_SHORT;
          end
        end
        ST_PRESS2: begin
          if (rel_edge) begin
            state_d = ST_IDLE;
            emit_l  = 1'b1;
            type_l  = EVT_DOUBLE;
          end
        end
        default:   state_d = ST_IDLE;
      endcase

      if (state_d != state_q) begin
        cnt_d = '0;
      end else if ((state_q == ST_PRESS1 || state_q == ST_GAP) && tick && cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
    end

    assign emit[gi]      = emit_l;
    assign emit_type[gi] = type_l;
  end

  // Round-robin: lowest pending index above last_grant, otherwise lowest pending overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = NUM_SW - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        lo_found = 1'b1;
        lo_idx   = SW_W'(k);
        if (k > int'(last_grant_q)) begin
          hi_found = 1'b1;
          hi_idx   = SW_W'(k);
        end
      end
    end
  end

  assign grant_idx = hi_found ? hi_idx : lo_idx;
  assign accept    = evt_valid_q & i_Evt_Ready;
  assign out_free  = ~evt_valid_q | accept;
  assign load      = out_free & lo_found;

  always_comb begin
    evt_valid_d  = evt_valid_q;
    evt_sw_d     = evt_sw_q;
    evt_type_d   = evt_type_q;
    last_grant_d = last_grant_q;
    led_d        = led_q;
    pend_d       = pend_q;
    ptype_d      = ptype_q;
    ovf_d        = ovf_q;

    if (out_free) evt_valid_d = lo_found;
    if (load) begin
      evt_sw_d          = grant_idx;
      evt_type_d        = ptype_q[grant_idx];
      last_grant_d      = grant_idx;
      pend_d[grant_idx] = 1'b0;
    end

    if (accept) begin
      case (evt_type_q)
        EVT_SHORT:  led_d[evt_sw_q] = ~led_q[evt_sw_q];
        EVT_DOUBLE: led_d[evt_sw_q] = 1'b1;
        EVT_LONG:   led_d[evt_sw_q] = 1'b0;
        default:    led_d = led_q;
      endcase
    end

    // A slot freed by this cycle's load may be refilled on the same edge.
    for (int k = 0; k < NUM_SW; k++) begin
      if (emit[k]) begin
        if (pend_d[k]) begin
          ovf_d = 1'b1;
        end else begin
          pend_d[k]  = 1'b1;
          ptype_d[k] = emit_type[k];
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      evt_valid_q  <= 1'b0;
      evt_sw_q     <= '0;
      evt_type_q   <= EVT_NONE;
      last_grant_q <= SW_W'(NUM_SW - 1);
      led_q        <= '0;
      pend_q       <= '0;
      ptype_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      evt_valid_q  <= evt_valid_d;
      evt_sw_q     <= evt_sw_d;
      evt_type_q   <= evt_type_d;
      last_grant_q <= last_grant_d;
      led_q        <= led_d;
      pend_q       <= pend_d;
      ptype_q      <= ptype_d;
      ovf_q        <= ovf_d;
    end
  end

  assign o_Evt_Valid = evt_valid_q;
  assign o_Evt_Sw    = evt_sw_q;
  assign o_Evt_Type  = evt_type_q;
  assign o_LED       = led_q;
  assign o_Overflow  = ovf_q;

endmodule
